// File: rtl/img_ctrl_pkg.sv
// img_ctrl_pkg: shared state encoding, default counter width and report-word layout
// for the image count controller.
package img_ctrl_pkg;
    localparam int CNT_W_DEF = 16;
    localparam int FIELD_W = 16;
    localparam int NAV_LSB = 16;
    localparam int SCI_LSB = 0;
    typedef enum logic [1:0] {IDLE, SNAP, PRESENT, CLEAR} state_t;
endpackage

// File: rtl/img_class_counter.sv
// img_class_counter: saturating up/down image counter for one class.
// Adds are gated by add_en; an add refused by add_en is flagged as rejected.
module img_class_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         add,
    input  logic         add_en,
    input  logic         remove,
    input  logic         clear,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_next,
    output logic         rejected
);
    logic add_ok;
    assign add_ok = add & add_en;
    assign rejected = add & ~add_en;
    always_comb
        cnt_next = clear ? '0 :
                   (add_ok & ~remove & ~&cnt) ? cnt + W'(1) :
                   (remove & ~add_ok & |cnt) ? cnt - W'(1) : cnt;
    always_ff @(posedge clk)
        if (!rst_n) cnt <= '0;
        else cnt <= cnt_next;
endmodule

// File: rtl/img_count_ctrl.sv
// img_count_ctrl: tracks nav/science image counts, reports them as a 32-bit word
// with a valid/ack handshake, and clears them on request.
module img_count_ctrl
    import img_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int MAX_STORED = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nav_img_added,
    input  logic        science_img_added,
    input  logic        nav_img_removed,
    input  logic        science_img_removed,
    input  logic        start_flush_numimg_reg,
    input  logic        numimg_ack,
    input  logic        clear_numimg_req,
    output logic [31:0] out_numimg_reg,
    output logic        out_valid_numimg_reg,
    output logic        store_full,
    output logic [7:0]  dropped_cnt
);
    state_t state, state_nx;
    logic pend, pend_nx, clr, nav_rej, sci_rej;
    logic [CNT_W-1:0] nav, sci, nav_nx, sci_nx;
    logic [CNT_W:0] sum_nx;
    logic [8:0] drop_sum;
    logic [31:0] snap_word;

    assign clr = state == CLEAR;

    img_class_counter #(.W(CNT_W)) u_nav (
        .clk(clk), .rst_n(rst_n), .add(nav_img_added), .add_en(~store_full),
        .remove(nav_img_removed), .clear(clr), .cnt(nav), .cnt_next(nav_nx), .rejected(nav_rej)
    );

    img_class_counter #(.W(CNT_W)) u_sci (
        .clk(clk), .rst_n(rst_n), .add(science_img_added), .add_en(~store_full),
        .remove(science_img_removed), .clear(clr), .cnt(sci), .cnt_next(sci_nx), .rejected(sci_rej)
    );

    assign sum_nx = {1'b0, nav_nx} + {1'b0, sci_nx};
    assign drop_sum = {1'b0, dropped_cnt} + 9'(nav_rej) + 9'(sci_rej);
    assign out_valid_numimg_reg = state == PRESENT;

    // Snapshot takes next-state counts so events in the SNAP cycle are included
    always_comb begin
        snap_word = '0;
        snap_word[NAV_LSB +: FIELD_W] = FIELD_W'(nav_nx);
        snap_word[SCI_LSB +: FIELD_W] = FIELD_W'(sci_nx);
    end

    always_comb begin
        state_nx = state;
        pend_nx = pend | clear_numimg_req;
        case (state)
            IDLE:
                if (start_flush_numimg_reg) state_nx = SNAP;
                else if (clear_numimg_req | pend) begin
                    state_nx = CLEAR;
                    pend_nx = 1'b0;
                end
            SNAP: state_nx = PRESENT;
            PRESENT:
                if (numimg_ack) begin
                    state_nx = pend_nx ? CLEAR : IDLE;
                    pend_nx = 1'b0;
                end
            default: begin
                state_nx = IDLE;
                pend_nx = clear_numimg_req;
            end
        endcase
    end

    always_ff @(posedge clk)
        if (!rst_n) begin
            state <= IDLE;
            pend <= 1'b0;
            out_numimg_reg <= '0;
            store_full <= 1'b0;
            dropped_cnt <= '0;
        end else begin
            state <= state_nx;
            pend <= pend_nx;
            store_full <= 32'(sum_nx) >= 32'(MAX_STORED);
            dropped_cnt <= clr ? '0 : drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (state == SNAP) out_numimg_reg <= snap_word;
        end
endmodule

// File: doc/img_count_ctrl.md
IMG_COUNT_CTRL -- requirements
Module: img_count_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the per-class counter width.
REQ-002 SHALL have parameter MAX_STORED, default 1024, the combined nav+science capacity of image storage.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port nav_img_added, input, 1, one-cycle pulse: nav image written to storage.
REQ-006 SHALL have port science_img_added, input, 1, one-cycle pulse: science image written.
REQ-007 SHALL have port nav_img_removed, input, 1, one-cycle pulse: nav image freed.
REQ-008 SHALL have port science_img_removed, input, 1, one-cycle pulse: science image freed.
REQ-009 SHALL have port start_flush_numimg_reg, input, 1, one-cycle request to report counts.
REQ-010 SHALL have port numimg_ack, input, 1, consumer accepted the reported word.
REQ-011 SHALL have port clear_numimg_req, input, 1, one-cycle request to zero both counters.
REQ-012 SHALL have port out_numimg_reg, output, 32, {nav[15:0], science[15:0]}.
REQ-013 SHALL have port out_valid_numimg_reg, output, 1, out_numimg_reg valid until acked.
REQ-014 SHALL have port store_full, output, 1, nav+science >= MAX_STORED.
REQ-015 SHALL have port dropped_cnt, output, 8, adds rejected while full; saturates at 255.

Function
REQ-016 SHALL count every add/remove pulse the cycle it is sampled; nav and science events in the same cycle SHALL both be applied (no priority).
REQ-017 SHALL leave a class counter unchanged when add and remove of that class coincide.
REQ-018 SHALL hold a counter at 0 on remove (no underflow) and at 2^CNT_W-1 on add (no wrap).
REQ-019 SHALL reject an add while store_full is high, increment dropped_cnt instead; removes always apply; two rejected adds in one cycle add 2 (saturating).
REQ-020 SHALL update store_full registered, one cycle after the counter change.
REQ-021 SHALL implement FSM IDLE, SNAP, PRESENT, CLEAR.
REQ-022 SHALL in IDLE: flush -> SNAP; clear -> CLEAR; both together -> SNAP then CLEAR (report precedes clear).
REQ-023 SHALL in SNAP latch counters (including same-cycle events) into out_numimg_reg, go PRESENT; out_valid_numimg_reg rises 2 cycles after flush pulse.
REQ-024 SHALL in PRESENT hold out_numimg_reg stable and out_valid_numimg_reg high until numimg_ack; ack cycle -> valid low next cycle, then IDLE (or CLEAR if pended).
REQ-025 SHALL ignore flush requests outside IDLE; SHALL pend one clear arriving outside IDLE.
REQ-026 SHALL in CLEAR zero both counters and dropped_cnt for one cycle, discarding same-cycle events, then IDLE.
REQ-027 SHALL ignore numimg_ack outside PRESENT.

Reset
REQ-028 SHALL on rst_n low at clock edge: state IDLE, counters 0, dropped_cnt 0, out_numimg_reg 0, out_valid_numimg_reg 0, store_full 0, pending clear 0; reset mid-PRESENT drops valid next cycle.

Structure
REQ-029 SHALL place FSM state encodings, CNT_W default and 32-bit report-word field offsets in shared package img_ctrl_pkg.
REQ-030 SHALL instantiate sub-module img_class_counter twice (nav, science): saturating up/down counter with add-enable, remove, clear.

Verification
REQ-031 SHALL cover: 3 nav adds, 2 science adds, flush -> valid 2 cycles later, word 0x0003_0002, held until ack.
REQ-032 SHALL cover: nav_img_added and science_img_added same cycle x5 -> word 0x0005_0005.
REQ-033 SHALL cover: MAX_STORED=4, 6 adds -> store_full=1, dropped_cnt=2; one remove -> store_full=0 one cycle later.
REQ-034 SHALL cover: remove at count 0 -> stays 0; clear during PRESENT -> word unchanged until ack, then counters 0.
REQ-035 SHALL cover: flush+clear same cycle with counts 7/1 -> word 0x0007_0001, then counters 0; rst_n low in PRESENT -> all outputs 0.
